// File: rtl/sub_16b_seq_pkg.sv
// Shared defaults and state encoding for the nibble-serial subtractor.
package sub_16b_seq_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_SLICE  = 4;
    localparam int DEF_NSLICE = DEF_WIDTH / DEF_SLICE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sub_16b_seq_if.sv
// Operand/result handshake bundle between the read stage and the writeback stage.
interface sub_16b_seq_if
    import sub_16b_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_bin;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_d;
    logic             o_bout;
    logic             o_ov;

    modport slave (
        input  i_valid, i_a, i_b, i_bin, i_ready,
        output o_ready, o_valid, o_d, o_bout, o_ov
    );

    modport master (
        output i_valid, i_a, i_b, i_bin, i_ready,
        input  o_ready, o_valid, o_d, o_bout, o_ov
    );
endinterface

// File: rtl/sub_16b_seq_sub_4b.sv
// Combinational slice subtract: d = a - b - bin, done as a + ~b + ~bin so the
// adder carry-out is the inverted borrow-out.
module sub_4b
    import sub_16b_seq_pkg::*;
#(
    parameter int W = DEF_SLICE
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] d,
    output logic         bout
);
    logic [W:0] sum;

    assign sum  = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, ~bin};
    assign d    = sum[W-1:0];
    assign bout = ~sum[W];
endmodule

// File: rtl/sub_16b_seq.sv
// Sequential subtractor: one SLICE-bit borrow-chain slice per clock, LSB first,
// with valid/ready on both sides.
module sub_16b_seq
    import sub_16b_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic         i_clk,
    input  logic         i_rst,
    sub_16b_seq_if.slave bus
);
    // WIDTH is expected to be a whole number of slices.
    localparam int NS = WIDTH / SLICE;
    localparam int CW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NS - 1);

    state_t                    state;
    logic [CW-1:0]             cnt;
    logic [NS-1:0][SLICE-1:0]  a_q, b_q, d_q;
    logic                      brw;
    logic                      vld_q, bout_q, ov_q;

    logic [SLICE-1:0]          s_d;
    logic                      s_bout;

    sub_4b #(.W(SLICE)) u_slice (
        .a    (a_q[cnt]),
        .b    (b_q[cnt]),
        .bin  (brw),
        .d    (s_d),
        .bout (s_bout)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= IDLE;
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            d_q    <= '0;
            brw    <= 1'b0;
            vld_q  <= 1'b0;
            bout_q <= 1'b0;
            ov_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_valid) begin
                        a_q   <= bus.i_a;
                        b_q   <= bus.i_b;
                        brw   <= bus.i_bin;
                        cnt   <= '0;
                        d_q   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    d_q[cnt] <= s_d;
                    brw      <= s_bout;
                    cnt      <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // Top slice: its borrow is the word borrow, its MSB is D's sign.
                        bout_q <= s_bout;
                        ov_q   <= (a_q[NS-1][SLICE-1] != b_q[NS-1][SLICE-1]) &&
                                  (s_d[SLICE-1] != a_q[NS-1][SLICE-1]);
                        vld_q  <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (bus.i_ready) begin
                        vld_q <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_ready = (state == IDLE);
    assign bus.o_valid = vld_q;
    assign bus.o_d     = d_q;
    assign bus.o_bout  = bout_q;
    assign bus.o_ov    = ov_q;
endmodule

// File: tb/tb_sub_16b_seq.sv
// Bench for sub_16b_seq: directed vector table, random ops against an
// arithmetic model, and hand-written backpressure / mid-op reset sequences.
module tb_sub_16b_seq;
    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    sub_16b_seq_if #(.WIDTH(16)) bus ();

    sub_16b_seq #(.WIDTH(16), .SLICE(4)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] d;
        logic        bout;
        logic        ov;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, unsigned for D/borrow, signed range for overflow.
    function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic bin,
                                  output logic [15:0] d, output logic bo, output logic ov);
        int u, s;
        u  = int'(a) - int'(b) - int'(bin);
        s  = int'($signed(a)) - int'($signed(b)) - int'(bin);
        d  = u[15:0];
        bo = (u < 0);
        ov = (s > 32767) || (s < -32768);
    endfunction

    // Called at a negedge; returns at the negedge where o_valid is first seen.
    // lat counts rising edges from acceptance to o_valid.
    task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic bin, output int lat);
        int w;
        w = 0;
        while (!bus.o_ready && w < 50) begin
            @(negedge i_clk);
            w++;
        end
        if (w >= 50) chk("ready_timeout", 0, 1);
        bus.i_a = a; bus.i_b = b; bus.i_bin = bin; bus.i_valid = 1'b1;
        @(negedge i_clk);
        bus.i_valid = 1'b0;
        lat = 0;
        while (!bus.o_valid && lat < 50) begin
            @(negedge i_clk);
            lat++;
        end
        if (lat >= 50) chk("valid_timeout", 0, 1);
    endtask

    vec_t vt[8];
    logic [15:0] ed, hd;
    logic        eb, eo, hb, ho;
    int          lat;

    initial begin
        vt[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
        vt[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vt[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        vt[3] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
        vt[4] = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vt[5] = '{16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0};
        vt[6] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vt[7] = '{16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b1};

        bus.i_valid = 1'b0; bus.i_a = '0; bus.i_b = '0; bus.i_bin = 1'b0; bus.i_ready = 1'b1;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("rst_o_valid", 32'(bus.o_valid), 0);
        chk("rst_o_d",     32'(bus.o_d),     0);
        chk("rst_o_bout",  32'(bus.o_bout),  0);
        chk("rst_o_ov",    32'(bus.o_ov),    0);
        chk("rst_o_ready", 32'(bus.o_ready), 1);

        // Directed table.
        foreach (vt[i]) begin
            bus.i_ready = 1'b1;
            launch(vt[i].a, vt[i].b, vt[i].bin, lat);
            chk($sformatf("vec%0d_lat", i),   32'(lat),          4);
            chk($sformatf("vec%0d_d", i),     32'(bus.o_d),      32'(vt[i].d));
            chk($sformatf("vec%0d_bout", i),  32'(bus.o_bout),   32'(vt[i].bout));
            chk($sformatf("vec%0d_ov", i),    32'(bus.o_ov),     32'(vt[i].ov));
            chk($sformatf("vec%0d_busy", i),  32'(bus.o_ready),  0);
            @(negedge i_clk);
            chk($sformatf("vec%0d_vclr", i),  32'(bus.o_valid),  0);
            chk($sformatf("vec%0d_rdy", i),   32'(bus.o_ready),  1);
        end

        // Random operations against the model.
        for (int n = 0; n < 60; n++) begin
            logic [15:0] ra, rb;
            logic        rc;
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            if (n % 8 == 0) rb = ra;
            model(ra, rb, rc, ed, eb, eo);
            bus.i_ready = 1'b1;
            launch(ra, rb, rc, lat);
            chk("rnd_lat",  32'(lat),        4);
            chk("rnd_d",    32'(bus.o_d),    32'(ed));
            chk("rnd_bout", 32'(bus.o_bout), 32'(eb));
            chk("rnd_ov",   32'(bus.o_ov),   32'(eo));
            @(negedge i_clk);
        end

        // Backpressure: hold in DONE, stray i_valid must be ignored.
        bus.i_ready = 1'b0;
        model(16'h4321, 16'h1234, 1'b1, ed, eb, eo);
        launch(16'h4321, 16'h1234, 1'b1, lat);
        hd = bus.o_d; hb = bus.o_bout; ho = bus.o_ov;
        chk("bp_d", 32'(hd), 32'(ed));
        for (int k = 0; k < 3; k++) begin
            bus.i_valid = (k == 1); bus.i_a = 16'h0F0F; bus.i_b = 16'h00FF; bus.i_bin = 1'b0;
            @(negedge i_clk);
            chk("bp_valid", 32'(bus.o_valid), 1);
            chk("bp_hold_d", 32'(bus.o_d), 32'(hd));
            chk("bp_hold_bout", 32'(bus.o_bout), 32'(hb));
            chk("bp_hold_ov", 32'(bus.o_ov), 32'(ho));
            chk("bp_ready", 32'(bus.o_ready), 0);
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        @(negedge i_clk);
        chk("bp_release_valid", 32'(bus.o_valid), 0);
        chk("bp_release_ready", 32'(bus.o_ready), 1);
        repeat (6) @(negedge i_clk);
        chk("bp_no_capture_valid", 32'(bus.o_valid), 0);
        chk("bp_no_capture_ready", 32'(bus.o_ready), 1);

        // Reset on the second RUN cycle discards the operation.
        bus.i_a = 16'h1234; bus.i_b = 16'h0001; bus.i_bin = 1'b0; bus.i_valid = 1'b1;
        @(negedge i_clk);
        bus.i_valid = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        chk("mrst_valid", 32'(bus.o_valid), 0);
        chk("mrst_d",     32'(bus.o_d),     0);
        chk("mrst_bout",  32'(bus.o_bout),  0);
        chk("mrst_ov",    32'(bus.o_ov),    0);
        chk("mrst_ready", 32'(bus.o_ready), 1);
        repeat (6) @(negedge i_clk);
        chk("mrst_no_result", 32'(bus.o_valid), 0);
        launch(16'h0010, 16'h0001, 1'b0, lat);
        chk("mrst_next_d",    32'(bus.o_d),    32'h000F);
        chk("mrst_next_bout", 32'(bus.o_bout), 0);
        @(negedge i_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
